// File: rtl/round_key_stack_if.sv
// ----------------------------------------------------------------------------
// round_key_stack_if
// Handshake bundle between the round-key buffer and its neighbours.
//   Write side (key expander -> buffer): wr_valid, wr_ready, wr_key
//   Read side  (buffer -> inverse rounds): rd_valid, rd_ready, rd_key, rd_round
// Modports:
//   master : producer/consumer view (drives wr_valid/wr_key/rd_ready)
//   slave  : buffer view (drives wr_ready/rd_valid/rd_key/rd_round)
// ----------------------------------------------------------------------------
interface round_key_stack_if #(
    parameter int KEY_WIDTH = 128
);
    logic                 wr_valid;
    logic                 wr_ready;
    logic [KEY_WIDTH-1:0] wr_key;
    logic                 rd_valid;
    logic                 rd_ready;
    logic [KEY_WIDTH-1:0] rd_key;
    logic [3:0]           rd_round;

    modport master (
        output wr_valid, wr_key, rd_ready,
        input  wr_ready, rd_valid, rd_key, rd_round
    );

    modport slave (
        input  wr_valid, wr_key, rd_ready,
        output wr_ready, rd_valid, rd_key, rd_round
    );
endinterface

// File: rtl/round_key_stack.sv
// ----------------------------------------------------------------------------
// round_key_stack
// Reverse-order round-key buffer for the decryption datapath. Round keys
// arrive in generation order 0..NUM_KEYS-1 and are replayed last-first, one
// per cycle. A stored schedule can be replayed repeatedly via `replay`.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous abort, back to LOAD with an empty schedule
//   replay   : pulse in HOLD to restart the reverse readout
//   full     : a complete schedule is stored (READ or HOLD)
//   empty    : LOAD with no keys accepted yet
//   bus      : write/read handshakes (round_key_stack_if.slave)
// ----------------------------------------------------------------------------
module round_key_stack #(
    parameter int KEY_WIDTH = 128,
    parameter int NUM_KEYS  = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 replay,
    output logic                 full,
    output logic                 empty,
    round_key_stack_if.slave     bus
);
    localparam logic [3:0] LAST = 4'(NUM_KEYS - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] wcnt_reg, wcnt_next;
    logic [3:0] rptr_reg, rptr_next;

    logic       wr_ready;
    logic       rd_valid;
    logic       wr_fire;
    logic       rd_fire;
    logic       mem_we;
    logic [3:0] mem_waddr;

    logic [KEY_WIDTH-1:0] mem_rd [NUM_KEYS];

    // Key storage: one register per round, written through a single
    // decoded write port.
    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_mem
            logic [KEY_WIDTH-1:0] entry_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (mem_we && (mem_waddr == 4'(gi))) begin
                    entry_reg <= bus.wr_key;
                end
            end

            assign mem_rd[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= LOAD;
            wcnt_reg  <= '0;
            rptr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            wcnt_reg  <= wcnt_next;
            rptr_reg  <= rptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        rptr_next  = rptr_reg;
        mem_we     = 1'b0;
        mem_waddr  = wcnt_reg;

        // Ready/valid depend only on state and the clear/replay controls, so
        // no combinational path exists from rd_ready or wr_valid.
        wr_ready = !clear && ((state_reg == LOAD) ||
                              ((state_reg == HOLD) && !replay));
        rd_valid = !clear && (state_reg == READ);
        wr_fire  = bus.wr_valid && wr_ready;
        rd_fire  = rd_valid && bus.rd_ready;

        if (clear) begin
            state_next = LOAD;
            wcnt_next  = '0;
            rptr_next  = '0;
        end else begin
            unique case (state_reg)
                LOAD: begin
                    if (wr_fire) begin
                        mem_we    = 1'b1;
                        mem_waddr = wcnt_reg;
                        if (wcnt_reg == LAST) begin
                            state_next = READ;
                            rptr_next  = LAST;
                            wcnt_next  = '0;
                        end else begin
                            wcnt_next = wcnt_reg + 4'd1;
                        end
                    end
                end
                READ: begin
                    if (rd_fire) begin
                        if (rptr_reg == 4'd0) begin
                            state_next = HOLD;
                        end else begin
                            rptr_next = rptr_reg - 4'd1;
                        end
                    end
                end
                HOLD: begin
                    // replay masks wr_ready, so wr_fire cannot coincide with it.
                    if (replay) begin
                        state_next = READ;
                        rptr_next  = LAST;
                    end else if (wr_fire) begin
                        mem_we     = 1'b1;
                        mem_waddr  = 4'd0;
                        wcnt_next  = 4'd1;
                        state_next = LOAD;
                    end
                end
                default: begin
                    state_next = LOAD;
                    wcnt_next  = '0;
                    rptr_next  = '0;
                end
            endcase
        end
    end

    assign bus.wr_ready = wr_ready;
    assign bus.rd_valid = rd_valid;
    assign bus.rd_key   = rd_valid ? mem_rd[rptr_reg] : '0;
    assign bus.rd_round = rd_valid ? rptr_reg : 4'd0;
    assign full         = (state_reg == READ) || (state_reg == HOLD);
    assign empty        = (state_reg == LOAD) && (wcnt_reg == 4'd0);
endmodule
